pad_in_filter: RTL and testbench

- Receive-side conditioning stage directly downstream of the functional pad wrappers; consumes each pad's O output.
- Per pad: synchronises O into clk_i, debounces it with a programmable stability count and exposes the clean level.
- Converts enabled rising/falling transitions into a single arbitrated valid/ready event stream for the event/interrupt logic.

---
 rtl/pad_in_filter_pkg.sv | 23 ++
 rtl/pad_in_filter_chan.sv | 57 +++++
 rtl/pad_in_filter.sv | 98 +++++++++
 tb/tb_pad_in_filter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pad_in_filter_pkg.sv
// Shared constants, event record type and priority helper for the pad input filter.
package pad_in_filter_pkg;

  localparam int DefNumPads = 8;
  localparam int DefCntW    = 8;
  localparam int DefIdxW    = (DefNumPads > 1) ? $clog2(DefNumPads) : 1;
  localparam int MaxPads    = 64;

  // Event record held in the output register; sized for the default pad count.
  typedef struct packed {
    logic [DefIdxW-1:0] pad;
    logic               rise;
  } evt_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int lowest_set(input logic [MaxPads-1:0] vec);
    lowest_set = 0;
    for (int i = MaxPads - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = i;
    end
  endfunction

endpackage

// File: rtl/pad_in_filter_chan.sv
// One pad: synchroniser, debounce counter and filtered level, plus edge pulses.
// Define PAD_IN_FILTER_SYNC3_EN for a 3-flop synchroniser (default 2 flops).
module pad_in_filter_chan
  import pad_in_filter_pkg::*;
#(
  parameter int CNT_W = DefCntW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pad_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] thresh_i,
  output logic             filt_o,
  output logic             rise_o,
  output logic             fall_o
);

`ifdef PAD_IN_FILTER_SYNC3_EN
  localparam int SyncLen = 3;
`else
  localparam int SyncLen = 2;
`endif

  logic [SyncLen-1:0] sync_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               filt_q;
  logic               s;
  logic               flip;

  assign s = sync_q[SyncLen-1];
  // >= lets a threshold lowered mid-count resolve on the next edge; since the
  // counter only increments while below the threshold it can never wrap.
  assign flip = en_i && (s != filt_q) && (cnt_q >= thresh_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncLen-2:0], pad_i};
      if (!en_i || (s == filt_q)) begin
        cnt_q <= '0;
      end else if (flip) begin
        filt_q <= s;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign filt_o = filt_q;
  assign rise_o = flip & s;
  assign fall_o = flip & ~s;

endmodule

// File: rtl/pad_in_filter.sv
// Pad receive filter: per-pad debounce plus one arbitrated valid/ready edge-event stream.
// Option macro: PAD_IN_FILTER_SYNC3_EN (3-flop synchronisers in each channel).
// Event stream: evt_pad_o/evt_rise_o are valid while evt_valid_o is high, held stable
// until evt_ready_i is seen high on a clock edge; the pair transfers on valid & ready.
module pad_in_filter
  import pad_in_filter_pkg::*;
#(
  parameter int NUM_PADS = DefNumPads,
  parameter int CNT_W    = DefCntW,
  parameter int IDX_W    = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_PADS-1:0] pad_i,
  input  logic [NUM_PADS-1:0] cfg_en_i,
  input  logic [CNT_W-1:0]    cfg_thresh_i,
  input  logic [NUM_PADS-1:0] cfg_rise_en_i,
  input  logic [NUM_PADS-1:0] cfg_fall_en_i,
  output logic [NUM_PADS-1:0] filt_o,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic [IDX_W-1:0]    evt_pad_o,
  output logic                evt_rise_o,
  output logic [NUM_PADS-1:0] ovf_o,
  input  logic [NUM_PADS-1:0] ovf_clr_i
);

  if (IDX_W != DefIdxW || NUM_PADS > MaxPads) begin : g_bad_cfg
    $error("pad_in_filter: NUM_PADS must match the evt_t sizing in pad_in_filter_pkg");
  end

  logic [NUM_PADS-1:0] rise_p, fall_p;
  logic [NUM_PADS-1:0] set_r, set_f, clr_r, clr_f;
  logic [NUM_PADS-1:0] pend_r_q, pend_f_q, pend_any;
  logic [NUM_PADS-1:0] ovf_q, ovf_set;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_rise;
  logic                load;
  logic                evt_valid_q;
  evt_t                evt_q;

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_chan
    pad_in_filter_chan #(.CNT_W(CNT_W)) u_chan (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .pad_i    (pad_i[i]),
      .en_i     (cfg_en_i[i]),
      .thresh_i (cfg_thresh_i),
      .filt_o   (filt_o[i]),
      .rise_o   (rise_p[i]),
      .fall_o   (fall_p[i])
    );
  end

  assign set_r    = rise_p & cfg_rise_en_i;
  assign set_f    = fall_p & cfg_fall_en_i;
  assign pend_any = pend_r_q | pend_f_q;
  assign load     = !evt_valid_q || evt_ready_i;

  // Lowest pad wins; within a pad the rising event goes first.
  always_comb begin
    clr_r    = '0;
    clr_f    = '0;
    sel_idx  = IDX_W'(lowest_set(MaxPads'(pend_any)));
    sel_rise = pend_r_q[sel_idx];
    if (load && (|pend_any)) begin
      if (sel_rise) clr_r[sel_idx] = 1'b1;
      else          clr_f[sel_idx] = 1'b1;
    end
  end

  // A set landing on the bit being loaded out is a fresh event, not an overflow.
  assign ovf_set = (set_r & pend_r_q & ~clr_r) | (set_f & pend_f_q & ~clr_f);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_r_q    <= '0;
      pend_f_q    <= '0;
      ovf_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_q       <= '0;
    end else begin
      pend_r_q <= (pend_r_q & ~clr_r) | set_r;
      pend_f_q <= (pend_f_q & ~clr_f) | set_f;
      ovf_q    <= (ovf_q & ~ovf_clr_i) | ovf_set;
      if (load) begin
        evt_valid_q <= |pend_any;
        if (|pend_any) evt_q <= '{pad: sel_idx, rise: sel_rise};
      end
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_pad_o   = evt_q.pad;
  assign evt_rise_o  = evt_q.rise;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_pad_in_filter.sv
// Directed bench for pad_in_filter: debounce timing, glitches, arbitration, overflow, disable.
module tb_pad_in_filter;

`ifdef PAD_IN_FILTER_SYNC3_EN
  localparam int X = 1;
`else
  localparam int X = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pad, en, rise_en, fall_en, ovf_clr;
  logic [7:0] thresh;
  logic       ready;
  logic [7:0] filt, ovf;
  logic       valid, rise;
  logic [2:0] evt_pad;

  int checks = 0;
  int errors = 0;

  pad_in_filter dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pad_i         (pad),
    .cfg_en_i      (en),
    .cfg_thresh_i  (thresh),
    .cfg_rise_en_i (rise_en),
    .cfg_fall_en_i (fall_en),
    .filt_o        (filt),
    .evt_valid_o   (valid),
    .evt_ready_i   (ready),
    .evt_pad_o     (evt_pad),
    .evt_rise_o    (rise),
    .ovf_o         (ovf),
    .ovf_clr_i     (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Each step passes one rising edge; inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_evt(input string tag, input logic v, input logic [2:0] p, input logic r);
    check({tag, "_valid"}, 32'(valid), 32'(v));
    if (v) begin
      check({tag, "_pad"}, 32'(evt_pad), 32'(p));
      check({tag, "_rise"}, 32'(rise), 32'(r));
    end
  endtask

  initial begin
    rst = 1'b1; pad = '0; en = 8'hFF; rise_en = 8'hFF; fall_en = 8'hFF;
    thresh = 8'd5; ready = 1'b0; ovf_clr = '0;
    step(3);
    check("rst_filt", 32'(filt), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check_evt("rst", 1'b0, 3'd0, 1'b0);
    check("rst_pad", 32'(evt_pad), 32'h0);
    check("rst_rise", 32'(rise), 32'h0);
    rst = 1'b0;
    step(2);

    // Reset mid-count discards the partially counted change.
    pad[0] = 1'b1;
    step(4);
    rst = 1'b1; pad[0] = 1'b0;
    step(1);
    check("midrst_filt", 32'(filt), 32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    step(2);
    rst = 1'b0;
    step(20);
    check("postrst_filt", 32'(filt), 32'h0);
    check("postrst_valid", 32'(valid), 32'h0);

    // Debounce timing: filt at edge thresh+3, event one edge later.
    thresh = 8'd3;
    pad[2] = 1'b1;
    for (int e = 1; e <= 7 + X; e++) begin
      step(1);
      check($sformatf("deb_filt_e%0d", e), 32'(filt[2]), 32'(e >= 6 + X));
      check($sformatf("deb_valid_e%0d", e), 32'(valid), 32'(e >= 7 + X));
    end
    check_evt("deb_evt", 1'b1, 3'd2, 1'b1);
    ready = 1'b1;
    step(1);
    check("deb_drain", 32'(valid), 32'h0);
    ready = 1'b0;

    // Glitch: 4-cycle pulse needs thresh+1 = 5 stable samples to pass.
    thresh = 8'd4;
    pad[1] = 1'b1;
    step(4);
    pad[1] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step(1);
      check($sformatf("glitch_filt_%0d", e), 32'(filt), 32'h04);
      check($sformatf("glitch_valid_%0d", e), 32'(valid), 32'h0);
    end

    // Arbitration and backpressure: pads 3 and 5 rise together.
    thresh = 8'd3;
    pad[3] = 1'b1; pad[5] = 1'b1;
    step(6 + X);
    check("arb_filt", 32'(filt), 32'h2C);
    for (int c = 0; c < 4; c++) begin
      step(1);
      check_evt($sformatf("arb_hold%0d", c), 1'b1, 3'd3, 1'b1);
    end
    ready = 1'b1;
    step(1);
    check_evt("arb_second", 1'b1, 3'd5, 1'b1);
    step(1);
    check("arb_empty", 32'(valid), 32'h0);
    ready = 1'b0;

    // Overflow: output occupied by pad6, pad0 rises, falls, rises again.
    thresh = 8'd1;
    pad[6] = 1'b1;
    step(6);
    check_evt("ovf_occ", 1'b1, 3'd6, 1'b1);
    pad[0] = 1'b1;
    step(6);
    pad[0] = 1'b0;
    step(6);
    check("ovf_none", 32'(ovf), 32'h0);
    pad[0] = 1'b1;
    step(6);
    check("ovf_set", 32'(ovf), 32'h01);
    check_evt("ovf_hold", 1'b1, 3'd6, 1'b1);
    ovf_clr[0] = 1'b1;
    step(1);
    ovf_clr[0] = 1'b0;
    check("ovf_clr", 32'(ovf), 32'h0);
    ready = 1'b1;
    step(1);
    check_evt("ovf_d0", 1'b1, 3'd0, 1'b1);
    step(1);
    check_evt("ovf_d1", 1'b1, 3'd0, 1'b0);
    step(1);
    check("ovf_d2", 32'(valid), 32'h0);
    ready = 1'b0;
    check("ovf_after", 32'(ovf), 32'h0);
    check("ovf_filt", 32'(filt), 32'h6D);

    // Disabled pad ignores toggling; re-enable with pad high gives a rise.
    en[4] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      pad[4] = ~pad[4];
      step(1);
      check($sformatf("dis_filt_%0d", c), 32'(filt[4]), 32'h0);
      check($sformatf("dis_valid_%0d", c), 32'(valid), 32'h0);
    end
    step(3);
    en[4] = 1'b1; pad[4] = 1'b1;
    for (int e = 1; e <= 5 + X; e++) begin
      step(1);
      check($sformatf("ren_filt_e%0d", e), 32'(filt[4]), 32'(e >= 4 + X));
      check($sformatf("ren_valid_e%0d", e), 32'(valid), 32'(e >= 5 + X));
    end
    check_evt("ren_evt", 1'b1, 3'd4, 1'b1);
    ready = 1'b1;
    step(1);
    check("ren_drain", 32'(valid), 32'h0);
    ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
